// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests and sequences exception/ertn
// redirection (freeze, drain fetch, one-cycle flush). PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallreq_ds,
  input  logic        stallreq_es,
  input  logic        stallreq_ms,
  input  logic        excp_valid,
  input  logic        excp_ertn,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        fetch_busy,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        new_pc_valid,
  output logic [31:0] new_pc,
  output logic        ctrl_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [5:0] FREEZE_MASK = 6'b011111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [5:0]  merge_stall;

  // Each request freezes its own stage and everything upstream of it.
  always_comb begin
    merge_stall = 6'b000000;
    if (stallreq_ds) merge_stall = merge_stall | 6'b000111;
    if (stallreq_es) merge_stall = merge_stall | 6'b001111;
    if (stallreq_ms) merge_stall = merge_stall | 6'b011111;
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    stall        = 6'b000000;
    flush        = 1'b0;
    new_pc_valid = 1'b0;
    new_pc       = target_q;
    ctrl_busy    = 1'b1;
    case (state_q)
      IDLE: begin
        ctrl_busy = 1'b0;
        stall     = merge_stall;
        if (excp_valid) begin
          target_d = excp_ertn ? csr_era : csr_eentry;
          stall    = merge_stall | FREEZE_MASK;
          state_d  = fetch_busy ? DRAIN : FLUSH;
        end
      end
      DRAIN: begin
        stall = FREEZE_MASK;
        if (!fetch_busy) state_d = FLUSH;
      end
      FLUSH: begin
        flush        = 1'b1;
        new_pc_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= PC_RESET;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall != 6'b000000) perf_stall_d = perf_stall_q + 32'd1;
    if (flush)              perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cnt    = perf_flush_q;
`endif

endmodule
